// File: rtl/qed_dup_sched.sv
// qed_dup_sched: segment scheduler for the QED instruction-duplication path.
// Counts original fetches into the QED i-cache and closes a segment on
// capacity, on seg_end, or when QED mode is dropped. It then holds duplicate
// mode until every cached instruction has been re-issued, waits for the
// pipeline to drain, and pulses qed_check.
module qed_dup_sched #(
  parameter int DEPTH     = 16,
  parameter int CNT_W     = 5,
  parameter int DRAIN_CYC = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             stall_IF,
  input  logic             vld_out,
  input  logic             seg_end,
  output logic             exec_dup,
  output logic             qed_check,
  output logic [CNT_W-1:0] orig_cnt
);

  // The drain counter only ever holds DRAIN_CYC-1 down to 0.
  localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ORIG  = 2'd1,
    ST_DUP   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   orig_cnt_q, orig_cnt_d;
  logic [CNT_W-1:0]   dup_cnt_q, dup_cnt_d;
  logic [DRN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic               exec_dup_q, exec_dup_d;
  logic               qed_check_q, qed_check_d;

  logic               fetch_s;
  logic               issue_s;
  logic [CNT_W-1:0]   orig_inc_s;
  logic [CNT_W-1:0]   dup_inc_s;

  // Next-state and counter logic for the segment FSM.
  always_comb begin
    state_d     = state_q;
    orig_cnt_d  = orig_cnt_q;
    dup_cnt_d   = dup_cnt_q;
    drain_cnt_d = drain_cnt_q;
    qed_check_d = 1'b0;

    fetch_s    = ~stall_IF;
    issue_s    = ~stall_IF & vld_out;
    orig_inc_s = orig_cnt_q + CNT_W'(1);
    dup_inc_s  = dup_cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        orig_cnt_d  = {CNT_W{1'b0}};
        dup_cnt_d   = {CNT_W{1'b0}};
        drain_cnt_d = {DRN_W{1'b0}};
        if (ena) begin
          state_d = ST_ORIG;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ORIG: begin
        if (fetch_s) begin
          // A fetch in the same cycle that ena drops is counted, then the
          // segment closes on it.
          orig_cnt_d = orig_inc_s;
          if ((orig_inc_s == DEPTH_C) || seg_end || !ena) begin
            state_d = ST_DUP;
          end else begin
            state_d = ST_ORIG;
          end
        end else if (!ena) begin
          if (orig_cnt_q == {CNT_W{1'b0}}) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DUP;
          end
        end else begin
          state_d = ST_ORIG;
        end
      end

      ST_DUP: begin
        if (issue_s) begin
          dup_cnt_d = dup_inc_s;
          if (dup_inc_s == orig_cnt_q) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRN_LOAD;
          end else begin
            state_d = ST_DUP;
          end
        end else begin
          state_d = ST_DUP;
        end
      end

      ST_DRAIN: begin
        // Counts down unconditionally: fetch only delivers bubbles here.
        if (drain_cnt_q == {DRN_W{1'b0}}) begin
          qed_check_d = 1'b1;
          orig_cnt_d  = {CNT_W{1'b0}};
          dup_cnt_d   = {CNT_W{1'b0}};
          if (ena) begin
            state_d = ST_ORIG;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          drain_cnt_d = drain_cnt_q - DRN_W'(1);
          state_d     = ST_DRAIN;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        orig_cnt_d  = {CNT_W{1'b0}};
        dup_cnt_d   = {CNT_W{1'b0}};
        drain_cnt_d = {DRN_W{1'b0}};
      end
    endcase

    exec_dup_d = (state_d == ST_DUP) || (state_d == ST_DRAIN);
  end

  // State and output registers; rst discards any open segment.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      orig_cnt_q  <= {CNT_W{1'b0}};
      dup_cnt_q   <= {CNT_W{1'b0}};
      drain_cnt_q <= {DRN_W{1'b0}};
      exec_dup_q  <= 1'b0;
      qed_check_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      orig_cnt_q  <= orig_cnt_d;
      dup_cnt_q   <= dup_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      exec_dup_q  <= exec_dup_d;
      qed_check_q <= qed_check_d;
    end
  end

  assign exec_dup  = exec_dup_q;
  assign qed_check = qed_check_q;
  assign orig_cnt  = orig_cnt_q;

endmodule

// File: doc/qed_dup_sched.md
# qed_dup_sched

Segment scheduler for the QED instruction-duplication path. Drives `exec_dup` for the QED wrapper: counts original instructions fetched into the QED instruction cache, closes a segment on capacity or on request, and holds duplicate mode until every cached instruction has been re-issued. After the pipeline drains it pulses `qed_check` to trigger the original-vs-duplicate consistency check. Sits beside the QED wrapper in the fetch stage, fed by the fetch stall and the cache's `vld_out`.

## Interface
- `DEPTH`, 16 — maximum original instructions per segment; must not exceed QED i-cache capacity; legal range 1..2^CNT_W-1.
- `CNT_W`, 5 — width of segment counters.
- `DRAIN_CYC`, 5 — cycles waited after the last duplicate issues before `qed_check`; ≥1.
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `ena`  in  1  QED mode enable.
- `stall_IF`  in  1  fetch stall; a fetch completes in a cycle with `stall_IF`=0.
- `vld_out`  in  1  QED cache presents a valid duplicate this cycle.
- `seg_end`  in  1  fetched original is the last of its segment (e.g. control-flow); sampled only with a completing fetch.
- `exec_dup`  out  1  registered; 1 = duplicate mode, to QED wrapper.
- `qed_check`  out  1  registered one-cycle pulse; segment complete and drained.
- `orig_cnt`  out  CNT_W  registered originals in current segment (debug/verification).

## Operation
- States: IDLE, ORIG, DUP, DRAIN. `exec_dup` = 1 in DUP and DRAIN, else 0.
- Reset: state IDLE, `exec_dup`=0, `qed_check`=0, `orig_cnt`=0, dup counter 0, drain counter 0.
- IDLE: counters held at 0. `ena`=1 → ORIG next cycle. No fetches counted in IDLE.
- ORIG: fetch = `stall_IF`=0.
  - Fetch: `orig_cnt`+1.
  - Fetch with `orig_cnt`+1 == DEPTH, or fetch with `seg_end`=1 → DUP.
  - `ena`=0 and `orig_cnt`=0 with no fetch → IDLE.
  - `ena`=0 and `orig_cnt`>0: → DUP next cycle; a same-cycle fetch is counted first.
- DUP: an issue is a cycle with `stall_IF`=0 and `vld_out`=1. Each issue increments the dup counter. On an issue with dup counter +1 == `orig_cnt` → DRAIN; load drain counter with DRAIN_CYC-1. Cycles with `vld_out`=0 or `stall_IF`=1 are not counted. `ena` and `seg_end` are ignored.
- DRAIN: `exec_dup` stays 1. The cache is empty (`vld_out`=0), so fetch delivers bubbles. The drain counter decrements every cycle regardless of stall. At 0: `qed_check`=1 for the next cycle, `orig_cnt` and dup counter clear, and the state goes to ORIG if `ena`=1, else IDLE.
- Invariant: dup counter ≤ `orig_cnt` ≤ DEPTH. No wrap-around is legal. Verification asserts this.
- `rst` mid-segment discards the segment. There is no `qed_check` and outputs take their reset values next cycle.

## Timing
- All outputs are registered and change only on a `clk` rising edge.
- `exec_dup` rises the cycle after the fetch that closes a segment. The first duplicate can issue that same cycle.
- `exec_dup` falls and `qed_check` pulses in the same cycle: DRAIN_CYC cycles after the final duplicate issue cycle.
- Minimum segment turnaround with no stalls, N originals: N fetch cycles + N issue cycles + DRAIN_CYC.
- `orig_cnt` updates the cycle after each counted fetch.
- Simultaneous `seg_end` and count reaching DEPTH: a single transition to DUP.
- `rst` has priority over every other input.

## Test plan
- DEPTH=4, DRAIN_CYC=2, `ena`=1, no stalls, `vld_out`=1 in DUP → `exec_dup` high after the 4th fetch; `qed_check` pulses 2 cycles after the 4th duplicate issue; `exec_dup` falls in that same cycle; `orig_cnt` returns to 0.
- DEPTH=16, `seg_end` asserted on the 3rd fetch → DUP with `orig_cnt`=3; exactly 3 issues precede DRAIN.
- In DUP, `stall_IF` toggled and `vld_out` gapped → only `stall_IF`=0 & `vld_out`=1 cycles count; DRAIN entered on the issue matching `orig_cnt`.
- In ORIG, `ena` dropped with `orig_cnt`=2 → DUP next cycle, 2 issues, `qed_check` pulses, then IDLE; with `orig_cnt`=0 → IDLE directly with no `qed_check`.
- `rst` asserted in DUP and separately in DRAIN → next cycle `exec_dup`=0, `qed_check`=0, `orig_cnt`=0, state IDLE, no pulse.
- Back-to-back segments, DEPTH=2, continuous fetch → alternating 2-fetch ORIG / 2-issue DUP / DRAIN; exactly one `qed_check` per segment.
